// File: rtl/lpif_tx_protid_arbiter.sv
// Two-requester flit arbiter and TX FIFO credit scheduler feeding the LPIF TX packer.
// Round-robins whole packets, holds multi-flit packets contiguous, issues only when ACTIVE with credit.
module lpif_tx_protid_arbiter #(
  parameter int          DATA_W  = 512,
  parameter int          CRC_W   = 16,
  parameter int          CREDITS = 8,
  parameter logic [1:0]  PROTID0 = 2'd0,
  parameter logic [1:0]  PROTID1 = 2'd1,
  localparam int         CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  input  logic [3:0]        lp_state,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_last,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_dvalid,
  input  logic [CRC_W-1:0]  req0_crc,
  input  logic              req0_crc_valid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_last,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_dvalid,
  input  logic [CRC_W-1:0]  req1_crc,
  input  logic              req1_crc_valid,
  input  logic              credit_return,
  output logic [3:0]        dstrm_state,
  output logic [1:0]        dstrm_protid,
  output logic [DATA_W-1:0] dstrm_data,
  output logic              dstrm_dvalid,
  output logic [CRC_W-1:0]  dstrm_crc,
  output logic              dstrm_crc_valid,
  output logic              dstrm_valid,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              credit_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [3:0]       ACTIVE_C  = 4'h1;

  state_t             state_r, state_nxt_s;
  logic               ptr_r, ptr_nxt_s;
  logic               grant_s, grant_vld_s;
  logic               can_issue_s, accept_s, last_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               err_nxt_s;

  assign can_issue_s = (lp_state == ACTIVE_C) && (credit_cnt != {CNT_W{1'b0}});
  assign req0_ready  = can_issue_s && grant_vld_s && !grant_s && req0_valid;
  assign req1_ready  = can_issue_s && grant_vld_s &&  grant_s && req1_valid;
  assign accept_s    = req0_ready || req1_ready;
  assign last_s      = grant_s ? req1_last : req0_last;

  // Grant selection: a locked packet owns the channel even while its source idles.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_vld_s = 1'b1;
          grant_s     = ptr_r;
        end else if (req0_valid) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b0;
        end else if (req1_valid) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b1;
        end else begin
          grant_vld_s = 1'b0;
          grant_s     = 1'b0;
        end
      end
      LOCK0: begin
        grant_vld_s = 1'b1;
        grant_s     = 1'b0;
      end
      LOCK1: begin
        grant_vld_s = 1'b1;
        grant_s     = 1'b1;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
      end
    endcase
  end

  // Packet lock and round-robin pointer update on each accepted flit.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    if (accept_s) begin
      if (last_s) begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = ~grant_s;
      end else begin
        state_nxt_s = grant_s ? LOCK1 : LOCK0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Credit accounting; a return with a full pool is a protocol error and is dropped.
  always_comb begin
    cnt_nxt_s = credit_cnt;
    err_nxt_s = credit_err;
    case ({accept_s, credit_return})
      2'b10: cnt_nxt_s = credit_cnt - ONE_C;
      2'b01: begin
        if (credit_cnt == CREDITS_C) begin
          err_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = credit_cnt + ONE_C;
        end
      end
      default: cnt_nxt_s = credit_cnt;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b0;
      credit_cnt <= CREDITS_C;
      credit_err <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      credit_cnt <= cnt_nxt_s;
      credit_err <= err_nxt_s;
    end
  end

  // Downstream channel registers; payload fields hold between flits.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      dstrm_state     <= 4'h0;
      dstrm_protid    <= 2'd0;
      dstrm_data      <= {DATA_W{1'b0}};
      dstrm_dvalid    <= 1'b0;
      dstrm_crc       <= {CRC_W{1'b0}};
      dstrm_crc_valid <= 1'b0;
      dstrm_valid     <= 1'b0;
    end else begin
      dstrm_state <= lp_state;
      if (accept_s) begin
        dstrm_protid    <= grant_s ? PROTID1 : PROTID0;
        dstrm_data      <= grant_s ? req1_data : req0_data;
        dstrm_dvalid    <= grant_s ? req1_dvalid : req0_dvalid;
        dstrm_crc       <= grant_s ? req1_crc : req0_crc;
        dstrm_crc_valid <= grant_s ? req1_crc_valid : req0_crc_valid;
        dstrm_valid     <= 1'b1;
      end else begin
        dstrm_dvalid    <= 1'b0;
        dstrm_crc_valid <= 1'b0;
        dstrm_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpif_tx_protid_arbiter.sv
// Directed vector bench for lpif_tx_protid_arbiter: arbitration, packet lock, credits,
// link-state stall and mid-packet reset, all against hand-computed expectations.
module tb_lpif_tx_protid_arbiter;

  localparam int DATA_W = 512;
  localparam int CRC_W  = 16;

  logic              clk_wr = 1'b0;
  logic              rst_wr;
  logic [3:0]        lp_state;
  logic              req0_valid, req0_ready, req0_last, req0_dvalid, req0_crc_valid;
  logic              req1_valid, req1_ready, req1_last, req1_dvalid, req1_crc_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic [CRC_W-1:0]  req0_crc, req1_crc;
  logic              credit_return;
  logic [3:0]        dstrm_state;
  logic [1:0]        dstrm_protid;
  logic [DATA_W-1:0] dstrm_data;
  logic              dstrm_dvalid, dstrm_crc_valid, dstrm_valid;
  logic [CRC_W-1:0]  dstrm_crc;
  logic [3:0]        credit_cnt;
  logic              credit_err;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  lpif_tx_protid_arbiter dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .lp_state(lp_state),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_last(req0_last),
    .req0_data(req0_data), .req0_dvalid(req0_dvalid), .req0_crc(req0_crc),
    .req0_crc_valid(req0_crc_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_last(req1_last),
    .req1_data(req1_data), .req1_dvalid(req1_dvalid), .req1_crc(req1_crc),
    .req1_crc_valid(req1_crc_valid),
    .credit_return(credit_return),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic [3:0] ls;
    logic       v0, l0, v1, l1, cr;
    logic       er0, er1, evld;
    logic [1:0] eprot;
    logic [3:0] ecnt;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [DATA_W-1:0] exp_data;
    logic [CRC_W-1:0]  exp_crc;
    k++;
    lp_state = v.ls;
    req0_valid = v.v0; req0_last = v.l0;
    req1_valid = v.v1; req1_last = v.l1;
    credit_return = v.cr;
    req0_data = DATA_W'(k * 2);
    req1_data = DATA_W'(k * 2 + 1);
    req0_crc  = CRC_W'(k * 2 + 16'h100);
    req1_crc  = CRC_W'(k * 2 + 16'h101);
    exp_data  = v.eprot[0] ? req1_data : req0_data;
    exp_crc   = v.eprot[0] ? req1_crc : req0_crc;
    #1;
    chk("req0_ready", DATA_W'(req0_ready), DATA_W'(v.er0));
    chk("req1_ready", DATA_W'(req1_ready), DATA_W'(v.er1));
    @(posedge clk_wr); #1;
    chk("dstrm_valid", DATA_W'(dstrm_valid), DATA_W'(v.evld));
    chk("dstrm_dvalid", DATA_W'({dstrm_dvalid, dstrm_crc_valid}), DATA_W'({v.evld, v.evld}));
    chk("dstrm_protid", DATA_W'(dstrm_protid), DATA_W'(v.eprot));
    chk("credit_cnt", DATA_W'(credit_cnt), DATA_W'(v.ecnt));
    chk("credit_err", DATA_W'(credit_err), DATA_W'(v.eerr));
    chk("dstrm_state", DATA_W'(dstrm_state), DATA_W'(v.ls));
    if (v.evld) begin
      chk("dstrm_data", dstrm_data, exp_data);
      chk("dstrm_crc", DATA_W'(dstrm_crc), DATA_W'(exp_crc));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, DATA_W'({dstrm_valid, dstrm_dvalid, dstrm_crc_valid}), DATA_W'(0));
    chk({tag, "_state"}, DATA_W'(dstrm_state), DATA_W'(0));
    chk({tag, "_protid"}, DATA_W'(dstrm_protid), DATA_W'(0));
    chk({tag, "_data"}, dstrm_data, DATA_W'(0));
    chk({tag, "_crc"}, DATA_W'(dstrm_crc), DATA_W'(0));
    chk({tag, "_cnt"}, DATA_W'(credit_cnt), DATA_W'(8));
    chk({tag, "_err"}, DATA_W'(credit_err), DATA_W'(0));
  endtask

  initial begin
    rst_wr = 1'b1; lp_state = 4'h0; credit_return = 1'b0;
    req0_valid = 1'b0; req0_last = 1'b0; req0_dvalid = 1'b1; req0_crc_valid = 1'b1;
    req1_valid = 1'b0; req1_last = 1'b0; req1_dvalid = 1'b1; req1_crc_valid = 1'b1;
    req0_data = '0; req1_data = '0; req0_crc = '0; req1_crc = '0;

    //            ls    v0 l0 v1 l1 cr  r0 r1 vld prot   cnt  err
    // single-flit packets from both, credits recycled -> alternation 0,1,0,1
    for (int i = 0; i < 4; i++)
      tbl.push_back('{4'h1, 1, 1, 1, 1, 1, ~i[0], i[0], 1, 2'(i[0]), 4'd8, 0});
    // 3-flit req0 packet with req1 waiting, then req1
    tbl.push_back('{4'h1, 1, 0, 1, 1, 1, 1, 0, 1, 2'd0, 4'd8, 0});
    tbl.push_back('{4'h1, 1, 0, 1, 1, 1, 1, 0, 1, 2'd0, 4'd8, 0});
    tbl.push_back('{4'h1, 1, 1, 1, 1, 1, 1, 0, 1, 2'd0, 4'd8, 0});
    tbl.push_back('{4'h1, 0, 0, 1, 1, 1, 0, 1, 1, 2'd1, 4'd8, 0});
    // drain all 8 credits with req0
    for (int i = 0; i < 8; i++)
      tbl.push_back('{4'h1, 1, 1, 0, 0, 0, 1, 0, 1, 2'd0, 4'(7 - i), 0});
    tbl.push_back('{4'h1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0});
    tbl.push_back('{4'h1, 1, 1, 0, 0, 1, 0, 0, 0, 2'd0, 4'd1, 0});
    tbl.push_back('{4'h1, 1, 1, 0, 0, 0, 1, 0, 1, 2'd0, 4'd0, 0});
    tbl.push_back('{4'h1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0});
    // refill to 5, then accept + return together
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'h1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'(i + 1), 0});
    tbl.push_back('{4'h1, 1, 1, 0, 0, 1, 1, 0, 1, 2'd0, 4'd5, 0});
    // refill to 8, overflow return sets sticky error
    for (int i = 0; i < 3; i++)
      tbl.push_back('{4'h1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'(i + 6), 0});
    tbl.push_back('{4'h1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'd8, 1});
    tbl.push_back('{4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd8, 1});

    repeat (2) @(posedge clk_wr);
    #1;
    chk_reset_vals("init_reset");
    rst_wr = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // 4-flit req1 packet interrupted by link leaving ACTIVE; req0 must wait
    apply('{4'h1, 0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 4'd7, 1});
    apply('{4'h1, 0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 4'd6, 1});
    apply('{4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 2'd1, 4'd6, 1});
    apply('{4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 2'd1, 4'd6, 1});
    apply('{4'h1, 1, 1, 1, 0, 0, 0, 1, 1, 2'd1, 4'd5, 1});
    apply('{4'h1, 1, 1, 1, 1, 0, 0, 1, 1, 2'd1, 4'd4, 1});
    apply('{4'h1, 1, 1, 0, 0, 0, 1, 0, 1, 2'd0, 4'd3, 1});

    // reset in the middle of a req1 packet
    apply('{4'h1, 0, 0, 1, 0, 0, 0, 1, 1, 2'd1, 4'd2, 1});
    req1_valid = 1'b1; req1_last = 1'b0; req0_valid = 1'b1; req0_last = 1'b1;
    lp_state = 4'h1; rst_wr = 1'b1;
    @(posedge clk_wr); #1;
    chk_reset_vals("mid_reset");
    rst_wr = 1'b0;
    // lock dropped, pointer back at 0 -> req0 wins
    apply('{4'h1, 1, 1, 1, 1, 0, 1, 0, 1, 2'd0, 4'd7, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
